// File: rtl/ysyx_25040105_ifu_pkg.sv
// ============================================================================
//  Module      : ysyx_25040105_ifu_pkg
//  Description : Shared definitions for the instruction fetch unit: reset PC
//                default, canonical NOP encoding, FSM state encoding and a
//                word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_25040105_ifu_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] C_INST_NOP = 32'h0000_0013;

    // REQ  : request presented on the memory port
    // WAIT : request accepted, waiting for the single response
    // HOLD : instruction latched and offered to the decode stage
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

    // Clears the two low bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040105_ifu.sv
// ============================================================================
//  Module      : ysyx_25040105_ifu
//  Description : Instruction fetch unit for a multi-cycle core. Holds the PC,
//                issues one word-aligned read per instruction (at most one
//                outstanding, no prefetch) and hands {inst, pc, fault} to the
//                decode stage over a valid/ready handshake. Accepts one-cycle
//                PC redirects from the execute/writeback side.
//  Ports       : clk, rst                      clock, sync active-high reset
//                mem_req_valid/ready/addr      fetch request channel
//                mem_rsp_valid/data/err        fetch response channel
//                redirect_valid/pc             PC redirect pulse and target
//                inst_valid/ready              handshake towards decode
//                inst, inst_pc, inst_fault     delivered instruction
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25040105_ifu
    import ysyx_25040105_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = C_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,

    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_err,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault
);

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] C_ALIGN   = ~ADDR_W'(3);

    ifu_state_e        state_q,      state_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;
    // Address currently presented on the request port. Kept apart from pc so
    // a redirect arriving in REQ does not disturb a request that must stay
    // stable until accepted.
    logic [ADDR_W-1:0] req_addr_q,   req_addr_d;
    // Set when the outstanding (or about to be accepted) fetch is stale and
    // its response must be dropped.
    logic              kill_q,       kill_d;
    logic [31:0]       inst_q,       inst_d;
    logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
    logic              inst_fault_q, inst_fault_d;

    logic [ADDR_W-1:0] w_target;

    assign w_target = redirect_pc & C_ALIGN;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        case (state_q)
            S_REQ: begin
                // The request still goes out at the old address; its
                // response is marked for discard.
                if (redirect_valid) begin
                    pc_d   = w_target;
                    kill_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d   = w_target;
                    kill_d = 1'b1;
                end
                if (mem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = mem_rsp_err ? 32'h0 : mem_rsp_data;
                        inst_fault_d = mem_rsp_err;
                        inst_pc_d    = req_addr_q;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (inst_ready) begin
                    pc_d    = redirect_valid ? w_target : (pc_q + C_PC_STEP);
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    // Squash the undelivered instruction.
                    pc_d    = w_target;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        // Freeze the request address on every entry into REQ.
        if ((state_q != S_REQ) && (state_d == S_REQ)) begin
            req_addr_d = pc_d;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            kill_q       <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (gated by rst so both valids are low while reset is held)
    // ------------------------------------------------------------------------
    assign mem_req_valid = (state_q == S_REQ)  && !rst;
    assign inst_valid    = (state_q == S_HOLD) && !rst;
    assign mem_req_addr  = req_addr_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_fault    = inst_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040105_ifu.sv
// ============================================================================
//  Module      : tb_ysyx_25040105_ifu
//  Description : Directed self-checking bench for the instruction fetch unit.
//                A small memory responder answers each accepted request with
//                ~addr one cycle later (optionally stalled / with error).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040105_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = 32'h0;
    logic        mem_rsp_err   = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int          n_cmp = 0;
    int          n_bad = 0;

    // memory responder state
    logic        r_pend  = 1'b0;
    logic [31:0] r_paddr = 32'h0;
    logic        r_stall = 1'b0;
    logic        r_err   = 1'b0;

    ysyx_25040105_ifu #(
        .ADDR_W   (32),
        .RESET_PC (32'h8000_0000)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: sample request handshake, advance, then update the memory
    // responder and clear the redirect pulse. Checks request/inst exclusion.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        if (rst) begin
            r_pend = 1'b0;
        end else if (acc) begin
            r_pend  = 1'b1;
            r_paddr = a;
        end
        if (r_pend && !r_stall && !rst) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ~r_paddr;
            mem_rsp_err   = r_err;
            r_pend        = 1'b0;
        end
        chk("req_inst_excl", {31'h0, mem_req_valid && inst_valid}, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req_valid",  {31'h0, mem_req_valid}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid},    32'h0);
        chk("rst_inst",       inst,                   32'h0);
        chk("rst_inst_pc",    inst_pc,                32'h0);
        chk("rst_inst_fault", {31'h0, inst_fault},    32'h0);
        rst = 1'b0;
        #1;
    endtask

    // Full zero-wait fetch of one instruction with inst_ready=1: REQ, WAIT, HOLD.
    task automatic fetch_one(input logic [31:0] addr);
        chk("req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("req_addr",  mem_req_addr,           addr);
        tick();
        chk("wait_no_inst", {31'h0, inst_valid}, 32'h0);
        tick();
        chk("hold_valid",  {31'h0, inst_valid}, 32'h1);
        chk("hold_inst",   inst,                ~addr);
        chk("hold_pc",     inst_pc,             addr);
        chk("hold_fault",  {31'h0, inst_fault}, 32'h0);
        tick();
    endtask

    initial begin
        // 1. reset + zero-wait stream
        do_reset();
        fetch_one(32'h8000_0000);
        fetch_one(32'h8000_0004);
        fetch_one(32'h8000_0008);

        // 2. request stalled by mem_req_ready low
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", {31'h0, mem_req_valid}, 32'h1);
            chk("stall_req_addr",  mem_req_addr,           32'h8000_0000);
            chk("stall_no_inst",   {31'h0, inst_valid},    32'h0);
            tick();
        end
        mem_req_ready = 1'b1;
        fetch_one(32'h8000_0000);

        // 3. decode back-pressure in HOLD
        inst_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",     {31'h0, inst_valid},    32'h1);
            chk("bp_inst",      inst,                   ~32'h8000_0004);
            chk("bp_pc",        inst_pc,                32'h8000_0004);
            chk("bp_fault",     {31'h0, inst_fault},    32'h0);
            chk("bp_no_req",    {31'h0, mem_req_valid}, 32'h0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        chk("bp_next_addr", mem_req_addr, 32'h8000_0008);

        // 4. redirect while waiting for the response
        r_stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        r_stall        = 1'b0;
        tick();
        chk("rw_no_inst0", {31'h0, inst_valid}, 32'h0);
        tick();
        chk("rw_no_inst1", {31'h0, inst_valid},    32'h0);
        chk("rw_req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("rw_req_addr",  mem_req_addr,           32'h8000_0100);
        fetch_one(32'h8000_0100);

        // 5. redirect during a completing handshake in HOLD at 8000_0010
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'h8000_0000 + 32'(i * 4));
        end
        tick();
        tick();
        chk("rh_valid", {31'h0, inst_valid}, 32'h1);
        chk("rh_pc",    inst_pc,             32'h8000_0010);
        chk("rh_inst",  inst,                ~32'h8000_0010);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        tick();
        chk("rh_req_addr", mem_req_addr, 32'h8000_0040);

        // 6. access fault
        r_err = 1'b1;
        tick();
        r_err = 1'b0;
        tick();
        chk("err_valid", {31'h0, inst_valid}, 32'h1);
        chk("err_fault", {31'h0, inst_fault}, 32'h1);
        chk("err_inst",  inst,                32'h0);
        chk("err_pc",    inst_pc,             32'h8000_0040);
        tick();
        chk("err_next_addr", mem_req_addr, 32'h8000_0044);

        // 7. redirect in REQ (request accepted at old address) then PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        chk("rq_old_addr", mem_req_addr, 32'h8000_0044);
        tick();
        chk("rq_wait_no_req", {31'h0, mem_req_valid}, 32'h0);
        tick();
        chk("rq_no_inst", {31'h0, inst_valid}, 32'h0);
        fetch_one(32'hFFFF_FFFC);
        chk("wrap_addr", mem_req_addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
